execute_stage: RTL and testbench

//  Execute stage of the 16-bit pipelined MIPS, directly downstream of Decode_Stage.

---
 rtl/execute_stage.sv | 212 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 16-bit pipelined MIPS.
//
// Registers the ALU result, store data, destination register, branch target and the
// memory/writeback controls into the EX/MEM outputs. An iterative shift-add multiplier
// (R-type funct 110) holds the upstream stages through 'stall' while it runs. 'flush'
// squashes the op in flight and aborts a running multiply.
//
// Configuration macro: EX_MUL_EN
//   defined   - multiplier FSM and stall logic are built
//   undefined - funct 110 gives result 0 with 1-cycle latency; stall tied to 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    turn this cycle's EX/MEM load into a bubble
//   PC_plus_two              PC+2 of the op in decode
//   read_data_1/2            operand A, operand B / store data
//   immediate                sign-extended immediate
//   rt, rd, funct            destination candidates, R-type function
//   RegDst..Branch, ALUOp    decode controls
//   stall                    hold PC, IF/ID and decode inputs this cycle
//   O_*                      registered EX/MEM outputs
module execute_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     PC_plus_two,
    input  logic [DATA_W-1:0]     read_data_1,
    input  logic [DATA_W-1:0]     read_data_2,
    input  logic [DATA_W-1:0]     immediate,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [2:0]            funct,
    input  logic                  RegDst,
    input  logic                  ALUSrc,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic [1:0]            ALUOp,
    output logic                  stall,
    output logic [DATA_W-1:0]     O_alu_result,
    output logic [DATA_W-1:0]     O_write_data,
    output logic [REG_ADDR_W-1:0] O_write_register,
    output logic [DATA_W-1:0]     O_branch_target,
    output logic                  O_zero,
    output logic                  O_MemtoReg,
    output logic                  O_RegWrite,
    output logic                  O_MemRead,
    output logic                  O_MemWrite,
    output logic                  O_Branch
);

    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     branch_target;
    logic [REG_ADDR_W-1:0] dest;
    logic [4:0]            ctl_in;   // {MemtoReg, RegWrite, MemRead, MemWrite, Branch}

    logic                  load_alu;
    logic                  load_mul;
    logic [DATA_W-1:0]     mul_result;
    logic [REG_ADDR_W-1:0] mul_dest;
    logic [4:0]            mul_ctl;

    assign op_b          = ALUSrc ? immediate : read_data_2;
    assign dest          = RegDst ? rd : rt;
    assign branch_target = PC_plus_two + (immediate << 1);
    assign ctl_in        = {MemtoReg, RegWrite, MemRead, MemWrite, Branch};

    // Single-cycle ALU; funct 110 yields 0 here, the product comes from the multiplier.
    always_comb begin
        alu_result = '0;
        unique case (ALUOp)
            2'b00: alu_result = read_data_1 + op_b;
            2'b01: alu_result = read_data_1 - op_b;
            2'b11: alu_result = read_data_1 & op_b;
            2'b10: begin
                case (funct)
                    3'b000: alu_result = read_data_1 + op_b;
                    3'b001: alu_result = read_data_1 - op_b;
                    3'b010: alu_result = read_data_1 & op_b;
                    3'b011: alu_result = read_data_1 | op_b;
                    3'b100: alu_result = {{(DATA_W-1){1'b0}},
                                          ($signed(read_data_1) < $signed(op_b))};
                    3'b101: alu_result = read_data_1 ^ op_b;
                    3'b110: alu_result = '0;
                    3'b111: alu_result = ~(read_data_1 | op_b);
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [DATA_W-1:0]  acc_q, a_q, b_q;
    logic [DATA_W-1:0]  mul_sum;
    logic               is_mul;
    logic               capture;
    logic               step;

    assign is_mul  = (ALUOp == 2'b10) && (funct == 3'b110) && RegWrite;
    // Accumulator value after this cycle's step; on the last step it is the product.
    assign mul_sum    = acc_q + (b_q[0] ? a_q : '0);
    assign mul_result = mul_sum;

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        capture  = 1'b0;
        step     = 1'b0;
        load_mul = 1'b0;
        load_alu = 1'b0;
        if (rst || flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_mul) begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = StBusy;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
                StBusy: begin
                    step  = 1'b1;
                    // Upstream advances on the final-step edge.
                    stall = (count_q != '0);
                    if (count_q == '0) begin
                        load_mul = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mul_dest <= '0;
            mul_ctl  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                count_q  <= CNT_W'(DATA_W - 1);
                acc_q    <= '0;
                a_q      <= read_data_1;
                b_q      <= op_b;
                mul_dest <= dest;
                mul_ctl  <= ctl_in;
            end else if (step) begin
                count_q <= count_q - CNT_W'(1);
                acc_q   <= mul_sum;
                a_q     <= a_q << 1;
                b_q     <= b_q >> 1;
            end
        end
    end
`else
    assign stall      = 1'b0;
    assign load_alu   = ~flush;
    assign load_mul   = 1'b0;
    assign mul_result = '0;
    assign mul_dest   = '0;
    assign mul_ctl    = '0;
`endif

    // EX/MEM register. A bubble clears only the controls; data fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            O_alu_result     <= '0;
            O_write_data     <= '0;
            O_write_register <= '0;
            O_branch_target  <= '0;
            O_zero           <= 1'b0;
            {O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch} <= 5'b0;
        end else if (load_alu) begin
            O_alu_result     <= alu_result;
            O_zero           <= (alu_result == '0);
            O_write_data     <= read_data_2;
            O_write_register <= dest;
            O_branch_target  <= branch_target;
            {O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch} <= ctl_in;
        end else if (load_mul) begin
            O_alu_result     <= mul_result;
            O_zero           <= (mul_result == '0);
            O_write_register <= mul_dest;
            {O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch} <= mul_ctl;
        end else begin
            {O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch} <= 5'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [15:0] PC_plus_two, read_data_1, read_data_2, immediate;
    logic [2:0]  rt, rd, funct;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;
    logic        stall;
    logic [15:0] O_alu_result, O_write_data, O_branch_target;
    logic [2:0]  O_write_register;
    logic        O_zero, O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch;

    int checks = 0;
    int errors = 0;

    execute_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .PC_plus_two(PC_plus_two), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .immediate(immediate), .rt(rt), .rd(rd), .funct(funct),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .stall(stall), .O_alu_result(O_alu_result), .O_write_data(O_write_data),
        .O_write_register(O_write_register), .O_branch_target(O_branch_target),
        .O_zero(O_zero), .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite),
        .O_MemRead(O_MemRead), .O_MemWrite(O_MemWrite), .O_Branch(O_Branch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  alu_op;
        logic [2:0]  fn;
        logic [15:0] a, b, imm, pc;
        logic        src, dst;
        logic [2:0]  rt_v, rd_v;
        logic [4:0]  ctl;      // {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
        logic [15:0] exp_res;
        logic        exp_zero;
        logic [2:0]  exp_wreg;
        logic [15:0] exp_bt;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [4:0] out_ctl();
        return {O_MemtoReg, O_RegWrite, O_MemRead, O_MemWrite, O_Branch};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] fn, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm, input logic [15:0] pc,
                         input logic src, input logic dst, input logic [2:0] rt_v,
                         input logic [2:0] rd_v, input logic [4:0] ctl);
        ALUOp = op; funct = fn; read_data_1 = a; read_data_2 = b; immediate = imm;
        PC_plus_two = pc; ALUSrc = src; RegDst = dst; rt = rt_v; rd = rd_v;
        {MemtoReg, RegWrite, MemRead, MemWrite, Branch} = ctl;
    endtask

    task automatic drive_idle();
        drive(2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0, 5'b00000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef EX_MUL_EN
    // Mul presented in cycle T; bubbles T+1..T+16, stall high T..T+15, result at T+17.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd_v,
                           input logic [15:0] exp, input string tag);
        drive(2'b10, 3'b110, a, b, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, rd_v, 5'b01000);
        #1;
        check({tag, " stall at T"}, 32'(stall), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check({tag, " bubble ctl"}, 32'(out_ctl()), 32'd0);
            check({tag, " busy stall"}, 32'(stall), (i <= 15) ? 32'd1 : 32'd0);
        end
        tick();
        check({tag, " result"}, 32'(O_alu_result), 32'(exp));
        check({tag, " ctl"}, 32'(out_ctl()), 32'b01000);
        check({tag, " wreg"}, 32'(O_write_register), 32'(rd_v));
        check({tag, " zero"}, 32'(O_zero), (exp == 16'h0) ? 32'd1 : 32'd0);
        drive_idle();
    endtask
`endif

    initial begin
        //          op     fn      a        b        imm      pc     src  dst  rt   rd  ctl       res     z  wr  bt
        vecs[0]  = '{2'b10, 3'b000, 16'h7FFF, 16'h0001, 16'h0004, 16'h0100, 0, 1, 3'd2, 3'd5, 5'b01000, 16'h8000, 0, 3'd5, 16'h0108};
        vecs[1]  = '{2'b01, 3'b000, 16'h1234, 16'h1234, 16'hFFFE, 16'h0010, 0, 0, 3'd3, 3'd1, 5'b00001, 16'h0000, 1, 3'd3, 16'h000C};
        vecs[2]  = '{2'b00, 3'b000, 16'h0100, 16'hDEAD, 16'h0020, 16'h0040, 1, 0, 3'd4, 3'd0, 5'b00010, 16'h0120, 0, 3'd4, 16'h0080};
        vecs[3]  = '{2'b11, 3'b000, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 0, 0, 3'd1, 3'd0, 5'b01000, 16'h3030, 0, 3'd1, 16'h0000};
        vecs[4]  = '{2'b10, 3'b001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd7, 5'b01000, 16'hFFFF, 0, 3'd7, 16'h0000};
        vecs[5]  = '{2'b10, 3'b010, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd6, 5'b01000, 16'h000F, 0, 3'd6, 16'h0000};
        vecs[6]  = '{2'b10, 3'b011, 16'h00F0, 16'h000F, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd1, 5'b01000, 16'h00FF, 0, 3'd1, 16'h0000};
        vecs[7]  = '{2'b10, 3'b100, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd2, 5'b01000, 16'h0001, 0, 3'd2, 16'h0000};
        vecs[8]  = '{2'b10, 3'b100, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd3, 5'b01000, 16'h0000, 1, 3'd3, 16'h0000};
        vecs[9]  = '{2'b10, 3'b101, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd4, 5'b01000, 16'h5555, 0, 3'd4, 16'h0000};
        vecs[10] = '{2'b10, 3'b111, 16'h0F0F, 16'h00FF, 16'h0000, 16'h0000, 0, 1, 3'd0, 3'd5, 5'b01000, 16'hF000, 0, 3'd5, 16'h0000};
        vecs[11] = '{2'b00, 3'b000, 16'hFFFF, 16'h0002, 16'h0001, 16'hFFFE, 0, 0, 3'd6, 3'd0, 5'b11100, 16'h0001, 0, 3'd6, 16'h0000};

        rst = 1'b1;
        flush = 1'b0;
        drive_idle();

        // Reset: two cycles, then mul-shaped inputs while reset is still held.
        tick();
        tick();
        check("reset alu_result", 32'(O_alu_result), 32'd0);
        check("reset write_data", 32'(O_write_data), 32'd0);
        check("reset write_reg", 32'(O_write_register), 32'd0);
        check("reset branch_target", 32'(O_branch_target), 32'd0);
        check("reset zero", 32'(O_zero), 32'd0);
        check("reset ctl", 32'(out_ctl()), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        drive(2'b10, 3'b110, 16'h0003, 16'h0003, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, 3'd1, 5'b01000);
        #1;
        check("reset mul stall", 32'(stall), 32'd0);
        tick();
        check("reset mul hold stall", 32'(stall), 32'd0);
        check("reset mul hold ctl", 32'(out_ctl()), 32'd0);
        drive_idle();
        rst = 1'b0;
        tick();

        // Single-cycle ops from the table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].alu_op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc,
                  vecs[i].src, vecs[i].dst, vecs[i].rt_v, vecs[i].rd_v, vecs[i].ctl);
            #1;
            check($sformatf("v%0d stall", i), 32'(stall), 32'd0);
            tick();
            check($sformatf("v%0d result", i), 32'(O_alu_result), 32'(vecs[i].exp_res));
            check($sformatf("v%0d zero", i), 32'(O_zero), 32'(vecs[i].exp_zero));
            check($sformatf("v%0d wreg", i), 32'(O_write_register), 32'(vecs[i].exp_wreg));
            check($sformatf("v%0d wdata", i), 32'(O_write_data), 32'(vecs[i].b));
            check($sformatf("v%0d btarget", i), 32'(O_branch_target), 32'(vecs[i].exp_bt));
            check($sformatf("v%0d ctl", i), 32'(out_ctl()), 32'(vecs[i].ctl));
        end

        // Flush in idle: bubble, data outputs hold the last op's values.
        drive(2'b00, 3'b000, 16'h0005, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 3'd2, 3'd0, 5'b01000);
        flush = 1'b1;
        #1;
        check("flush idle stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        check("flush idle ctl", 32'(out_ctl()), 32'd0);
        check("flush idle result hold", 32'(O_alu_result), 32'h0001);
        drive_idle();
        tick();

`ifdef EX_MUL_EN
        run_mul(16'h0013, 16'h0007, 3'd6, 16'h0085, "mul19x7");
        tick();
        run_mul(16'hFFFF, 16'hFFFF, 3'd3, 16'h0001, "mulFx F");
        tick();

        // Flush at T+5 aborts the multiply; the following add completes normally.
        drive(2'b10, 3'b110, 16'h0013, 16'h0007, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, 3'd4, 5'b01000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("abort bubble ctl", 32'(out_ctl()), 32'd0);
        end
        check("abort stall before flush", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        check("abort stall at flush", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        check("abort ctl", 32'(out_ctl()), 32'd0);
        drive(2'b10, 3'b000, 16'h0003, 16'h0004, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, 3'd2, 5'b01000);
        #1;
        check("abort next stall", 32'(stall), 32'd0);
        tick();
        check("abort next result", 32'(O_alu_result), 32'h0007);
        check("abort next ctl", 32'(out_ctl()), 32'b01000);
        check("abort next wreg", 32'(O_write_register), 32'd2);
        drive_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort no late result", 32'(out_ctl()), 32'd0);
        end
`else
        // Without the multiplier, funct 110 completes in one cycle with result 0.
        drive(2'b10, 3'b110, 16'h0013, 16'h0007, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, 3'd5, 5'b01000);
        #1;
        check("nomul stall", 32'(stall), 32'd0);
        tick();
        check("nomul result", 32'(O_alu_result), 32'd0);
        check("nomul zero", 32'(O_zero), 32'd1);
        check("nomul ctl", 32'(out_ctl()), 32'b01000);
        check("nomul wreg", 32'(O_write_register), 32'd5);
        drive_idle();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
